// File: rtl/fc_neuron_acc_pkg.sv
// Shared definitions for the fully connected layer accumulator: FP32 field
// widths, the accumulator state encoding and small FP32 field helpers.
package fc_neuron_acc_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IN,
        S_ISSUE,
        S_WAIT_SUM,
        S_DONE
    } state_t;

    // +0 and -0 both count as zero; the sign bit is ignored.
    function automatic logic fp_is_zero(input logic [FP_W-1:0] x);
        return (x[FP_W-2:0] == '0);
    endfunction

    // All-ones exponent: infinity or NaN.
    function automatic logic fp_exp_is_max(input logic [FP_W-1:0] x);
        return (x[FP_W-2 -: EXP_W] == EXP_MAX);
    endfunction

endpackage

// File: rtl/fc_neuron_acc.sv
// Per-neuron dot-product accumulator. Folds a stream of FP32 products into
// one sum, optionally seeded with a bias, using an external single-cycle
// FP32 adder one add at a time. Zero products are skipped, and the first
// non-zero value goes straight into the accumulator because the adder has
// no zero handling.
module fc_neuron_acc
    import fc_neuron_acc_pkg::*;
#(
    parameter  int N_IN  = 16,
    localparam int CNT_W = $clog2(N_IN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [FP_W-1:0] bias,
    output logic            busy,
    input  logic [FP_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [FP_W-1:0] add_a,
    output logic [FP_W-1:0] add_b,
    output logic            add_v,
    input  logic [FP_W-1:0] add_sum,
    input  logic            add_valid,
    output logic [FP_W-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_ovf
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN);

    state_t           state;
    state_t           state_next;
    logic [FP_W-1:0]  acc;
    logic [FP_W-1:0]  b_reg;
    logic             acc_empty;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             take;
    logic             in_zero;
    logic             needs_add;

    assign count_inc = count + CNT_W'(1);
    assign take      = (state == S_WAIT_IN) && in_valid;
    assign in_zero   = fp_is_zero(in_data);
    assign needs_add = !in_zero && !acc_empty;
    assign add_a     = acc;
    assign add_b     = b_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the handshake outputs, all derived from state.
    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        in_ready   = 1'b0;
        add_v      = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                in_ready = 1'b1;
                if (take) begin
                    if (needs_add)              state_next = S_ISSUE;
                    else if (count_inc == LAST) state_next = S_DONE;
                end
            end
            S_ISSUE: begin
                add_v      = 1'b1;
                state_next = S_WAIT_SUM;
            end
            S_WAIT_SUM: begin
                if (add_valid) state_next = (count == LAST) ? S_DONE : S_WAIT_IN;
            end
            S_DONE: begin
                out_valid = 1'b1;
                out_data  = acc;
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Accumulator, pending operand, product count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            b_reg     <= '0;
            acc_empty <= 1'b1;
            count     <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc       <= bias;
                        acc_empty <= fp_is_zero(bias);
                        count     <= '0;
                        out_ovf   <= 1'b0;
                    end
                end
                S_WAIT_IN: begin
                    if (take) begin
                        count <= count_inc;
                        if (!in_zero) begin
                            if (acc_empty) begin
                                acc       <= in_data;
                                acc_empty <= 1'b0;
                            end else begin
                                b_reg <= in_data;
                            end
                        end
                    end
                end
                S_WAIT_SUM: begin
                    if (add_valid) begin
                        acc <= add_sum;
                        if (fp_exp_is_max(add_sum)) out_ovf   <= 1'b1;
                        if (fp_is_zero(add_sum))    acc_empty <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
